key_code_translator: RTL and testbench
======================================

# key_code_translator

Parametrised, table-driven successor to the fixed key-code mapping components. It translates an input key code to a platform virtual-key code. The mapping table is loaded at run time through a write port, not wired in as constant inputs, and the lookup is a multi-lane sequential search. It sits behind the same call/return handshake as the other HLS-style components in the hotkey path.

## Interface
Parameters:
- CODE_W, 32, width of the input key code
- VKEY_W, 16, width of the virtual-key result
- DEPTH, 128, number of table entries; must be a multiple of LANES
- LANES, 4, entries compared per search cycle
- INVALID_KEY, {VKEY_W{1'b1}}, result returned on a miss

Ports (clock and reset first):
- clock  in  1  sole clock; all flops on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  call valid
- busy  out  1  call stall; high whenever the state is not IDLE
- code  in  CODE_W  key code to translate; sampled when start is accepted
- done  out  1  return valid
- stall  in  1  return stall from downstream
- returndata  out  VKEY_W  translated virtual key, or INVALID_KEY
- hit  out  1  high with done when a valid entry matched
- tbl_we  in  1  table write strobe
- tbl_ready  out  1  table write accepted; equals state==IDLE
- tbl_addr  in  $clog2(DEPTH)  entry index
- tbl_code  in  CODE_W  key code stored in the entry
- tbl_vkey  in  VKEY_W  virtual key stored in the entry
- tbl_valid  in  1  entry valid bit; 0 deletes the entry

## Operation
- FSM states: IDLE, SEARCH, DONE. Reset state is IDLE.
- IDLE:
  - start accepted when state==IDLE: latch code, set group counter g=0, go to SEARCH.
  - A tbl_we with tbl_ready high writes the entry this cycle.
  - If tbl_we and start are high together, both are taken. The search sees the new entry.
- SEARCH:
  - Each cycle, compare entries g*LANES .. g*LANES+LANES-1 against the latched code. A lane matches only if its entry's valid bit is 1 and its code is equal.
  - On any match, select the lowest-index matching lane, register its vkey and set hit=1, go to DONE.
  - If there is no match and g==DEPTH/LANES-1, register INVALID_KEY and set hit=0, go to DONE.
  - Otherwise g increments.
- DONE: done=1. returndata and hit hold steady. Go to IDLE on the first cycle with stall==0.
- tbl_we while busy is ignored. The table must not change mid-search.
- Duplicate codes in the table: the lowest index wins.
- Reset clears all DEPTH valid bits and the FSM. Entry code/vkey storage is not reset.
- A reset mid-search aborts the search with no done pulse.
- Output reset values: busy=0, done=0, hit=0, returndata=0, tbl_ready=1.

## Timing
- start accepted at cycle T.
- Match in group g: done rises at T+g+2.
- Full miss: done rises at T+DEPTH/LANES+1.
- done stays high for at least one cycle and holds while stall=1.
- The first cycle back in IDLE (done low) can accept a new start. Back-to-back calls are spaced by at least one idle cycle.
- A table write is visible to a start accepted in the same or any later cycle.

## Configuration
- KEY_XLATE_CACHE_EN defined: adds a one-entry last-result cache holding code, vkey, hit and a valid bit.
  - On an accepted start whose code equals the cached code while the cache is valid, the FSM goes straight to DONE with the cached result. done rises at T+1.
  - The cache updates at every search completion, whether a hit or a miss.
  - The cache is invalidated by any accepted tbl_we and by reset.
- KEY_XLATE_CACHE_EN undefined: no cache logic. Every call searches, and latency is as in Timing.

## Test plan
- Reset, then call code=0x41 with an empty table -> done at T+33 (DEPTH=128, LANES=4), returndata=INVALID_KEY, hit=0.
- Write entry 5 = {0x41, 0x0000}, then call 0x41 -> done at T+3 (group 1), returndata=0x0000, hit=1.
- Write entry 9 = {0x30, 0x001D} and entry 2 = {0x30, 0x0012}, then call 0x30 -> returndata=0x0012 (lowest index wins).
- Hold stall=1 for 4 cycles during DONE -> done and returndata stable for 5 cycles. Pulse tbl_we during SEARCH -> table unchanged, tbl_ready=0.
- With KEY_XLATE_CACHE_EN, repeat the call for 0x41 -> done at T+1. Then write any entry and call 0x41 again -> full-search latency.
- Assert reset in the second SEARCH cycle -> busy=0 and done=0 immediately; a later call on 0x41 misses because the valid bits were cleared.

Source files
------------

// File: rtl/key_code_translator.sv
// key_code_translator: table-driven key code -> virtual-key translator.
// The table is written through a run-time port and searched LANES entries per
// cycle behind a start/busy/done/stall call-return handshake.
// Optional feature: define KEY_XLATE_CACHE_EN to add a one-entry last-result cache.
module key_code_translator #(
    parameter int                  CODE_W      = 32,
    parameter int                  VKEY_W      = 16,
    parameter int                  DEPTH       = 128,
    parameter int                  LANES       = 4,
    parameter logic [VKEY_W-1:0]   INVALID_KEY = {VKEY_W{1'b1}},
    localparam int                 AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic [CODE_W-1:0] code,
    output logic              done,
    input  logic              stall,
    output logic [VKEY_W-1:0] returndata,
    output logic              hit,
    input  logic              tbl_we,
    output logic              tbl_ready,
    input  logic [AW-1:0]     tbl_addr,
    input  logic [CODE_W-1:0] tbl_code,
    input  logic [VKEY_W-1:0] tbl_vkey,
    input  logic              tbl_valid
);

    localparam int NGRP = DEPTH / LANES;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_hit;
    logic [VKEY_W-1:0]   r_rdata;
    logic [GW-1:0]       r_grp;
    logic [CODE_W-1:0]   r_key;

    logic [DEPTH-1:0]    r_valid;
    logic [CODE_W-1:0]   r_code [DEPTH];
    logic [VKEY_W-1:0]   r_vkey [DEPTH];

    logic                w_tbl_wr;
    logic                w_match;
    logic [VKEY_W-1:0]   w_mvkey;
    logic                w_last;
    logic [AW-1:0]       w_idx;

`ifdef KEY_XLATE_CACHE_EN
    logic                r_c_valid;
    logic [CODE_W-1:0]   r_c_code;
    logic [VKEY_W-1:0]   r_c_vkey;
    logic                r_c_hit;
    logic                w_c_use;
`endif

    // Writes are only taken while idle so the table never changes mid-search.
    assign w_tbl_wr   = tbl_we && (r_state == S_IDLE);
    assign w_last     = (r_grp == GW'(NGRP - 1));

    assign busy       = r_busy;
    assign tbl_ready  = ~r_busy;
    assign done       = r_done;
    assign hit        = r_hit;
    assign returndata = r_rdata;

`ifdef KEY_XLATE_CACHE_EN
    // A same-cycle table write may change the answer, so it bypasses the cache.
    assign w_c_use = r_c_valid && !tbl_we && (code == r_c_code);
`endif

    // Entry valid bits: cleared by reset so an empty table always misses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else if (w_tbl_wr) begin
            r_valid[tbl_addr] <= tbl_valid;
        end
    end

    // Entry code/vkey storage: plain RAM-style writes, no reset.
    always_ff @(posedge clock) begin
        if (w_tbl_wr) begin
            r_code[tbl_addr] <= tbl_code;
            r_vkey[tbl_addr] <= tbl_vkey;
        end
    end

    // Compare one group of lanes; scanning high to low leaves the lowest matching lane.
    always_comb begin
        w_match = 1'b0;
        w_mvkey = '0;
        w_idx   = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            w_idx = AW'(int'(r_grp) * LANES + l);
            if (r_valid[w_idx] && (r_code[w_idx] == r_key)) begin
                w_match = 1'b1;
                w_mvkey = r_vkey[w_idx];
            end
        end
    end

`ifdef KEY_XLATE_CACHE_EN
    // Cache payload: captured at every search completion.
    always_ff @(posedge clock) begin
        if ((r_state == S_SEARCH) && (w_match || w_last)) begin
            r_c_code <= r_key;
            r_c_vkey <= w_match ? w_mvkey : INVALID_KEY;
            r_c_hit  <= w_match;
        end
    end
`endif

    // Call/return FSM with registered handshake outputs and result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= 1'b0;
            r_rdata   <= '0;
            r_grp     <= '0;
            r_key     <= '0;
`ifdef KEY_XLATE_CACHE_EN
            r_c_valid <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef KEY_XLATE_CACHE_EN
                    if (w_tbl_wr) begin
                        r_c_valid <= 1'b0;
                    end
`endif
                    if (start) begin
                        r_key  <= code;
                        r_grp  <= '0;
                        r_busy <= 1'b1;
`ifdef KEY_XLATE_CACHE_EN
                        if (w_c_use) begin
                            r_rdata <= r_c_vkey;
                            r_hit   <= r_c_hit;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SEARCH;
                        end
`else
                        r_state <= S_SEARCH;
`endif
                    end
                end
                S_SEARCH: begin
                    if (w_match || w_last) begin
                        r_rdata <= w_match ? w_mvkey : INVALID_KEY;
                        r_hit   <= w_match;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`ifdef KEY_XLATE_CACHE_EN
                        r_c_valid <= 1'b1;
`endif
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        r_done  <= 1'b0;
                        r_hit   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_code_translator.sv
// tb_key_code_translator: directed self-checking bench for key_code_translator
// (default parameters DEPTH=128, LANES=4; honours KEY_XLATE_CACHE_EN).
module tb_key_code_translator;

    localparam int CODE_W = 32;
    localparam int VKEY_W = 16;
    localparam int DEPTH  = 128;
    localparam int LANES  = 4;
    localparam int AW     = 7;
    localparam logic [VKEY_W-1:0] INV = 16'hFFFF;
    localparam int MISS_LAT = DEPTH / LANES + 1;
`ifdef KEY_XLATE_CACHE_EN
    localparam int CACHED_LAT = 1;
`else
    localparam int CACHED_LAT = 3;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic [CODE_W-1:0] code = '0;
    logic              done;
    logic              stall = 1'b0;
    logic [VKEY_W-1:0] returndata;
    logic              hit;
    logic              tbl_we = 1'b0;
    logic              tbl_ready;
    logic [AW-1:0]     tbl_addr = '0;
    logic [CODE_W-1:0] tbl_code = '0;
    logic [VKEY_W-1:0] tbl_vkey = '0;
    logic              tbl_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    key_code_translator #(
        .CODE_W(CODE_W), .VKEY_W(VKEY_W), .DEPTH(DEPTH), .LANES(LANES), .INVALID_KEY(INV)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .code(code),
        .done(done), .stall(stall), .returndata(returndata), .hit(hit),
        .tbl_we(tbl_we), .tbl_ready(tbl_ready), .tbl_addr(tbl_addr),
        .tbl_code(tbl_code), .tbl_vkey(tbl_vkey), .tbl_valid(tbl_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [31:0] c, input logic [15:0] v, input logic vl);
        @(negedge clock);
        tbl_we = 1'b1; tbl_addr = AW'(a); tbl_code = c; tbl_vkey = v; tbl_valid = vl;
        @(negedge clock);
        tbl_we = 1'b0;
    endtask

    // Issue one call; latency is counted in cycles from the start cycle to done.
    task automatic call(input string tag, input logic [31:0] k, input int exp_lat,
                        input logic [15:0] exp_v, input logic exp_h, input bit mid_we,
                        input bit same_wr, input int wr_addr, input logic [15:0] wr_vkey);
        int n;
        @(negedge clock);
        start = 1'b1; code = k;
        if (same_wr) begin
            tbl_we = 1'b1; tbl_addr = AW'(wr_addr); tbl_code = k; tbl_vkey = wr_vkey; tbl_valid = 1'b1;
        end
        @(negedge clock);
        start = 1'b0; tbl_we = 1'b0; n = 1;
        while (done !== 1'b1 && n < 100) begin
            tbl_we = 1'b0;
            if (n == 1) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_rdy"}, tbl_ready, 0);
                if (mid_we) begin
                    tbl_we = 1'b1; tbl_addr = 7'd5; tbl_code = 32'h41;
                    tbl_vkey = 16'h7777; tbl_valid = 1'b0;
                end
            end
            @(negedge clock);
            n++;
        end
        tbl_we = 1'b0;
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_data"}, returndata, exp_v);
        chk({tag, "_hit"}, hit, exp_h);
        if (!stall) begin
            @(negedge clock);
            chk({tag, "_done_low"}, done, 0);
            chk({tag, "_idle"}, busy, 0);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit", hit, 0);
        chk("rst_data", returndata, 0);
        chk("rst_rdy", tbl_ready, 1);
        reset = 1'b0;

        // Empty table: full miss
        call("miss_empty", 32'h41, MISS_LAT, INV, 1'b0, 0, 0, 0, 0);

        // Entry 5 lives in group 1
        wr(5, 32'h41, 16'h0000, 1'b1);
        call("grp1", 32'h41, 3, 16'h0000, 1'b1, 0, 0, 0, 0);

        // Repeat call: cache path when enabled
        call("repeat", 32'h41, CACHED_LAT, 16'h0000, 1'b1, 0, 0, 0, 0);

        // Any write invalidates the cache
        wr(100, 32'h55, 16'h0001, 1'b1);
        call("after_wr", 32'h41, 3, 16'h0000, 1'b1, 0, 0, 0, 0);

        // Duplicate codes: lowest index wins
        wr(9, 32'h30, 16'h001D, 1'b1);
        wr(2, 32'h30, 16'h0012, 1'b1);
        call("dup", 32'h30, 2, 16'h0012, 1'b1, 0, 0, 0, 0);

        // Last-group hit held under stall
        wr(127, 32'h99, 16'h00AB, 1'b1);
        stall = 1'b1;
        call("last_grp", 32'h99, MISS_LAT, 16'h00AB, 1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("stall_done", done, 1);
            chk("stall_data", returndata, 16'h00AB);
        end
        stall = 1'b0;
        @(negedge clock);
        chk("stall_release", done, 0);

        // Write during SEARCH is ignored
        call("mid_we", 32'h41, 3, 16'h0000, 1'b1, 1, 0, 0, 0);
        call("mid_we_after", 32'h41, CACHED_LAT, 16'h0000, 1'b1, 0, 0, 0, 0);

        // Reset in the second SEARCH cycle aborts the call
        @(negedge clock);
        start = 1'b1; code = 32'h41;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rdy", tbl_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        call("post_rst", 32'h41, MISS_LAT, INV, 1'b0, 0, 0, 0, 0);

        // Write and start in the same cycle: search sees the new entry
        call("same_cyc", 32'h77, 2, 16'h0042, 1'b1, 0, 1, 0, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
